instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Parametrised IF stage for the MIPS pipeline, replacing the fixed 32-bit fetch.
- Contains the program counter, next-PC selection (sequential, jump, stall), an internal instruction memory with a loader write port, and a registered IF/ID output with a valid bit.
- Contains a LOAD/RUN/HALTED control FSM that stops fetching when the halt word is fetched.
- Sits between the debug/loader unit and the decode stage.

Parameters:
- PC_WIDTH, 32, width of PC and all address ports.
- INSTR_WIDTH, 32, instruction word width.
- IMEM_DEPTH, 256, instruction memory depth in words (power of 2); AW = clog2(IMEM_DEPTH).
- RESET_PC, 0, PC value after reset and on re-entering LOAD (word-aligned).
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- mips_enable  in  1  0 = load mode (memory writable, no fetch); 1 = run.
- stall  in  1  hazard stall from decode; holds PC and IF/ID.
- jump  in  1  take pc_with_jump this cycle.
- pc_with_jump  in  PC_WIDTH  jump/branch target byte address.
- wr_en  in  1  loader write strobe; honoured only in LOAD.
- address_to_write  in  PC_WIDTH  loader byte address.
- instruction_to_write  in  INSTR_WIDTH  loader data.
- program_counter  out  PC_WIDTH  current fetch PC.
- if_id_instruction  out  INSTR_WIDTH  registered fetched instruction.
- if_id_pc_plus4  out  PC_WIDTH  registered PC+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  FSM is in HALTED.
- addr_error  out  1  sticky flag: fetch or write address was out of range.

Behaviour:
- Reset (reset=0, asynchronous) drives:
  - program_counter = RESET_PC; FSM = LOAD.
  - if_id_instruction = 0; if_id_pc_plus4 = 0; if_id_valid = 0.
  - halted = 0; addr_error = 0.
  - Memory contents are not cleared.
- Word index is addr[AW+1:2]; addr[1:0] is ignored (masked). An address is out of range when any bit above AW+1 is set.
- Memory: combinational read at program_counter; synchronous write on clk when state==LOAD and wr_en=1.
  - Out-of-range write is dropped and sets addr_error.
  - Out-of-range fetch returns 0 (NOP) and sets addr_error.
- FSM:
  - LOAD: PC held at RESET_PC; if_id_valid=0; no fetch. Goes to RUN when mips_enable=1.
  - RUN: fetches each cycle; next-PC rules below apply. Goes to HALTED when the instruction being latched into IF/ID (not squashed, not stalled) equals HALT_WORD. The halt word itself is passed on with if_id_valid=1, so decode can drain it.
  - HALTED: halted=1; PC frozen at the halt address+4; if_id_valid=0 from the next cycle. Goes to LOAD when mips_enable=0, which also reloads PC to RESET_PC.
  - RUN with mips_enable=0 goes to LOAD (abort); IF/ID is invalidated.
- Next-PC and IF/ID in RUN, priority high to low:
  1. jump=1: PC <= {pc_with_jump[PC_WIDTH-1:2], 2'b00}; IF/ID <= bubble (valid=0, instruction=0). Jump wins over a simultaneous stall.
  2. stall=1: PC and IF/ID held unchanged.
  3. Otherwise: IF/ID <= {mem[PC], PC+4, valid=1}; PC <= PC+4.
- PC+4 wraps modulo 2^PC_WIDTH with no error. Wrap past IMEM_DEPTH is caught by the out-of-range rule.
- Latency: an instruction at address A appears on if_id_* one cycle after program_counter==A in RUN.
- stall and jump are ignored outside RUN.
- addr_error clears only on reset.

Decomposition:
- Shared package holds:
  - FSM state encoding: ST_LOAD=2'd0, ST_RUN=2'd1, ST_HALTED=2'd2.
  - NOP_WORD = 0 and the default HALT_WORD.
  - The clog2 helper.
- One sub-module, instr_mem: parametrised INSTR_WIDTH x IMEM_DEPTH array with one synchronous write port and one combinational read port. It is the replacement for the old reg_file instance.
- PC, next-PC mux, FSM and IF/ID register stay in the top module.

Test Plan:
- Load then run: in LOAD write 0x11,0x22,0x33,HALT_WORD at addresses 0,4,8,12; raise mips_enable. Expect:
  - if_id_instruction 0x11,0x22,0x33,HALT_WORD on consecutive cycles with valid=1 and if_id_pc_plus4 4,8,12,16.
  - halted=1 one cycle after HALT_WORD is latched; PC frozen at 16.
- Stall: assert stall for 2 cycles while PC=8. Expect PC=8 and IF/ID holding 0x22/pc_plus4=8 for both cycles, then 0x33 on the next cycle.
- Jump with stall: jump=1, stall=1, pc_with_jump=0x0000_0006. Expect PC=4 (masked), if_id_valid=0 the next cycle, then mem[1] with pc_plus4=8.
- Async reset mid-run: pull reset low between clock edges at PC=8. Expect PC=RESET_PC, if_id_valid=0, FSM=LOAD immediately; memory contents retained.
- Out of range, IMEM_DEPTH=16: jump to 0x40. Expect if_id_instruction=0 with valid=1 and addr_error=1 (sticky). A write to 0x40 in LOAD does not alter mem[0].
- Write gating: wr_en=1 in RUN to address 0 with 0xDEAD. Expect mem[0] unchanged. Abort to LOAD via mips_enable=0: expect PC=RESET_PC and if_id_valid=0.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_pkg
// Shared definitions for the MIPS instruction fetch stage:
//   - state_t           : LOAD / RUN / HALTED control FSM encoding
//   - NOP_WORD          : instruction returned for out-of-range fetches
//   - DEFAULT_HALT_WORD : default encoding that stops fetching
//   - clog2()           : address-width helper for parameter arithmetic
// ---------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  // Smallest r with 2**r >= value; evaluated at elaboration time only.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_instr_mem.sv
// ---------------------------------------------------------------------------
// instr_mem
// INSTR_WIDTH x IMEM_DEPTH instruction store. One synchronous write port
// (driven by the loader) and one combinational read port (driven by the PC).
// Contents have no reset, so a program survives a core reset.
// Ports:
//   clk      in   rising-edge clock
//   wr_en    in   write strobe (already gated by the caller)
//   wr_addr  in   AW-bit word index for writes
//   wr_data  in   INSTR_WIDTH write data
//   rd_addr  in   AW-bit word index for reads
//   rd_data  out  INSTR_WIDTH read data (combinational)
// ---------------------------------------------------------------------------
module instr_mem
  import instruction_fetch_unit_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int IMEM_DEPTH  = 256,
  parameter int AW          = clog2(IMEM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [INSTR_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]          rd_addr,
  output logic [INSTR_WIDTH-1:0] rd_data
);

  logic [INSTR_WIDTH-1:0] mem [IMEM_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// IF stage of the MIPS pipeline: program counter, next-PC selection
// (jump > stall > sequential), instruction memory with a loader port, the
// IF/ID pipeline register and a LOAD/RUN/HALTED control FSM.
// Ports:
//   clk                  in   rising-edge clock
//   reset                in   asynchronous, active-low reset
//   mips_enable          in   0 = load mode, 1 = run
//   stall                in   hold PC and IF/ID (RUN only)
//   jump                 in   load PC from pc_with_jump (RUN only)
//   pc_with_jump         in   jump target byte address
//   wr_en                in   loader write strobe (LOAD only)
//   address_to_write     in   loader byte address
//   instruction_to_write in   loader data
//   program_counter      out  current fetch PC
//   if_id_instruction    out  registered fetched instruction
//   if_id_pc_plus4       out  registered PC+4 of that instruction
//   if_id_valid          out  IF/ID holds a real instruction
//   halted               out  FSM is in HALTED
//   addr_error           out  sticky out-of-range fetch/write flag
// ---------------------------------------------------------------------------
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                     PC_WIDTH    = 32,
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     IMEM_DEPTH  = 256,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = DEFAULT_HALT_WORD
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mips_enable,
  input  logic                   stall,
  input  logic                   jump,
  input  logic [PC_WIDTH-1:0]    pc_with_jump,
  input  logic                   wr_en,
  input  logic [PC_WIDTH-1:0]    address_to_write,
  input  logic [INSTR_WIDTH-1:0] instruction_to_write,
  output logic [PC_WIDTH-1:0]    program_counter,
  output logic [INSTR_WIDTH-1:0] if_id_instruction,
  output logic [PC_WIDTH-1:0]    if_id_pc_plus4,
  output logic                   if_id_valid,
  output logic                   halted,
  output logic                   addr_error
);

  localparam int AW = clog2(IMEM_DEPTH);

  state_t                 state;
  logic                   fetch_oor;
  logic                   write_oor;
  logic                   mem_we;
  logic [INSTR_WIDTH-1:0] mem_word;
  logic [INSTR_WIDTH-1:0] fetch_word;
  logic [PC_WIDTH-1:0]    pc_plus4;
  logic [PC_WIDTH-1:0]    jump_target;

  // Any address bit above the word-index field means the address lies
  // beyond the memory; the low two byte-offset bits are simply ignored.
  assign fetch_oor   = (program_counter >> (AW + 2)) != '0;
  assign write_oor   = (address_to_write >> (AW + 2)) != '0;
  assign pc_plus4    = program_counter + PC_WIDTH'(4);
  assign jump_target = pc_with_jump & ~PC_WIDTH'(3);
  assign mem_we      = (state == ST_LOAD) && wr_en && !write_oor;
  assign fetch_word  = fetch_oor ? INSTR_WIDTH'(NOP_WORD) : mem_word;

  instr_mem #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .IMEM_DEPTH  (IMEM_DEPTH),
    .AW          (AW)
  ) u_imem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (address_to_write[AW+1:2]),
    .wr_data (instruction_to_write),
    .rd_addr (program_counter[AW+1:2]),
    .rd_data (mem_word)
  );

  // Control FSM, PC and IF/ID register. Everything observable is registered
  // here so halted/if_id_valid change on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= ST_LOAD;
      program_counter   <= RESET_PC;
      if_id_instruction <= '0;
      if_id_pc_plus4    <= '0;
      if_id_valid       <= 1'b0;
      halted            <= 1'b0;
      addr_error        <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          program_counter <= RESET_PC;
          if_id_valid     <= 1'b0;
          halted          <= 1'b0;
          if (wr_en && write_oor) addr_error <= 1'b1;
          if (mips_enable) state <= ST_RUN;
        end

        ST_RUN: begin
          if (!mips_enable) begin
            state           <= ST_LOAD;
            program_counter <= RESET_PC;
            if_id_valid     <= 1'b0;
          end else if (jump) begin
            // Jump squashes the instruction fetched this cycle, even when
            // decode is also asking for a stall.
            program_counter   <= jump_target;
            if_id_instruction <= '0;
            if_id_valid       <= 1'b0;
          end else if (!stall) begin
            program_counter   <= pc_plus4;
            if_id_instruction <= fetch_word;
            if_id_pc_plus4    <= pc_plus4;
            if_id_valid       <= 1'b1;
            if (fetch_oor) addr_error <= 1'b1;
            // The halt word is still handed to decode so it can drain.
            if (fetch_word == HALT_WORD) begin
              state  <= ST_HALTED;
              halted <= 1'b1;
            end
          end
        end

        ST_HALTED: begin
          if_id_valid <= 1'b0;
          if (!mips_enable) begin
            state           <= ST_LOAD;
            program_counter <= RESET_PC;
            halted          <= 1'b0;
          end
        end

        default: begin
          state           <= ST_LOAD;
          program_counter <= RESET_PC;
          if_id_valid     <= 1'b0;
          halted          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Self-checking bench for instruction_fetch_unit (IMEM_DEPTH = 16 so that
// byte address 0x40 is the first out-of-range address). Expected IF/ID
// contents are pushed to a scoreboard queue as stimulus is applied and
// popped when the corresponding clock edge has produced the output.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam int          PW    = 32;
  localparam int          IW    = 32;
  localparam int          DEPTH = 16;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mips_enable = 1'b0;
  logic          stall = 1'b0;
  logic          jump = 1'b0;
  logic [PW-1:0] pc_with_jump = '0;
  logic          wr_en = 1'b0;
  logic [PW-1:0] address_to_write = '0;
  logic [IW-1:0] instruction_to_write = '0;
  logic [PW-1:0] program_counter;
  logic [IW-1:0] if_id_instruction;
  logic [PW-1:0] if_id_pc_plus4;
  logic          if_id_valid;
  logic          halted;
  logic          addr_error;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [PW-1:0] pc4;
    logic          valid;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  instruction_fetch_unit #(
    .PC_WIDTH    (PW),
    .INSTR_WIDTH (IW),
    .IMEM_DEPTH  (DEPTH),
    .RESET_PC    (32'h0),
    .HALT_WORD   (HALT)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .mips_enable          (mips_enable),
    .stall                (stall),
    .jump                 (jump),
    .pc_with_jump         (pc_with_jump),
    .wr_en                (wr_en),
    .address_to_write     (address_to_write),
    .instruction_to_write (instruction_to_write),
    .program_counter      (program_counter),
    .if_id_instruction    (if_id_instruction),
    .if_id_pc_plus4       (if_id_pc_plus4),
    .if_id_valid          (if_id_valid),
    .halted               (halted),
    .addr_error           (addr_error)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [PW-1:0] a, input logic [IW-1:0] d);
    wr_en                = 1'b1;
    address_to_write     = a;
    instruction_to_write = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic enter_run();
    mips_enable = 1'b1;
    tick();
  endtask

  task automatic abort_run();
    mips_enable = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (program_counter !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_pc: got %h, expected %h", program_counter, 32'h0);
    end
    n_checks++;
    if ({if_id_instruction, if_id_pc_plus4, if_id_valid} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_ifid: got instr=%h pc4=%h valid=%b, expected all zero",
               if_id_instruction, if_id_pc_plus4, if_id_valid);
    end
    n_checks++;
    if ({halted, addr_error} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got halted=%b addr_error=%b, expected 0 0", halted, addr_error);
    end
    reset = 1'b1;
  endtask

  task automatic test_load_run();
    exp_t e;
    logic [31:0] prog [4];
    prog[0] = 32'h11; prog[1] = 32'h22; prog[2] = 32'h33; prog[3] = HALT;
    for (int i = 0; i < 4; i++) load_word(32'(i * 4), prog[i]);
    for (int i = 0; i < 4; i++) sb.push_back('{prog[i], 32'((i + 1) * 4), 1'b1});
    enter_run();
    for (int i = 0; i < 4; i++) begin
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({if_id_instruction, if_id_pc_plus4, if_id_valid} !== e) begin
        n_fail++;
        $display("[TB] FAIL run_ifid[%0d]: got instr=%h pc4=%h valid=%b, expected instr=%h pc4=%h valid=%b",
                 i, if_id_instruction, if_id_pc_plus4, if_id_valid, e.instr, e.pc4, e.valid);
      end
      if (i == 2) begin
        n_checks++;
        if (halted !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL early_halt: got halted=%b, expected 0", halted);
        end
      end
    end
    tick();
    n_checks++;
    if ({halted, if_id_valid, program_counter} !== {1'b1, 1'b0, 32'd16}) begin
      n_fail++;
      $display("[TB] FAIL halted_state: got halted=%b valid=%b pc=%h, expected 1 0 00000010",
               halted, if_id_valid, program_counter);
    end
    abort_run();
    n_checks++;
    if ({halted, program_counter} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("[TB] FAIL halt_to_load: got halted=%b pc=%h, expected 0 00000000", halted, program_counter);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    exp_t steps [5];
    logic stall_seq [5];
    steps[0] = '{32'h11, 32'd4, 1'b1};  stall_seq[0] = 1'b0;
    steps[1] = '{32'h22, 32'd8, 1'b1};  stall_seq[1] = 1'b0;
    steps[2] = '{32'h22, 32'd8, 1'b1};  stall_seq[2] = 1'b1;
    steps[3] = '{32'h22, 32'd8, 1'b1};  stall_seq[3] = 1'b1;
    steps[4] = '{32'h33, 32'd12, 1'b1}; stall_seq[4] = 1'b0;
    enter_run();
    for (int i = 0; i < 5; i++) begin
      stall = stall_seq[i];
      sb.push_back(steps[i]);
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({if_id_instruction, if_id_pc_plus4, if_id_valid} !== e || program_counter !== e.pc4) begin
        n_fail++;
        $display("[TB] FAIL stall_step[%0d]: got instr=%h pc4=%h valid=%b pc=%h, expected instr=%h pc4=%h valid=1 pc=%h",
                 i, if_id_instruction, if_id_pc_plus4, if_id_valid, program_counter, e.instr, e.pc4, e.pc4);
      end
    end
    stall = 1'b0;
    abort_run();
  endtask

  task automatic test_jump_stall();
    exp_t e;
    enter_run();
    tick();
    tick();
    jump = 1'b1; stall = 1'b1; pc_with_jump = 32'h0000_0006;
    tick();
    jump = 1'b0; stall = 1'b0;
    n_checks++;
    if ({program_counter, if_id_valid, if_id_instruction} !== {32'd4, 1'b0, 32'h0}) begin
      n_fail++;
      $display("[TB] FAIL jump_bubble: got pc=%h valid=%b instr=%h, expected 00000004 0 00000000",
               program_counter, if_id_valid, if_id_instruction);
    end
    sb.push_back('{32'h22, 32'd8, 1'b1});
    tick();
    e = sb.pop_front();
    n_checks++;
    if ({if_id_instruction, if_id_pc_plus4, if_id_valid} !== e) begin
      n_fail++;
      $display("[TB] FAIL jump_target_fetch: got instr=%h pc4=%h valid=%b, expected instr=%h pc4=%h valid=%b",
               if_id_instruction, if_id_pc_plus4, if_id_valid, e.instr, e.pc4, e.valid);
    end
    abort_run();
  endtask

  task automatic test_async_reset();
    exp_t e;
    enter_run();
    tick();
    tick();
    #3;
    reset = 1'b0;
    mips_enable = 1'b0;
    #1;
    n_checks++;
    if ({program_counter, if_id_valid, halted} !== {32'h0, 1'b0, 1'b0} || dut.state !== ST_LOAD) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got pc=%h valid=%b halted=%b state=%0d, expected 00000000 0 0 %0d",
               program_counter, if_id_valid, halted, dut.state, ST_LOAD);
    end
    #2;
    reset = 1'b1;
    enter_run();
    sb.push_back('{32'h11, 32'd4, 1'b1});
    sb.push_back('{32'h22, 32'd8, 1'b1});
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({if_id_instruction, if_id_pc_plus4, if_id_valid} !== e) begin
        n_fail++;
        $display("[TB] FAIL mem_retained[%0d]: got instr=%h pc4=%h valid=%b, expected instr=%h pc4=%h valid=%b",
                 i, if_id_instruction, if_id_pc_plus4, if_id_valid, e.instr, e.pc4, e.valid);
      end
    end
    abort_run();
  endtask

  task automatic test_out_of_range();
    exp_t e;
    n_checks++;
    if (addr_error !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL oor_pre: got addr_error=%b, expected 0", addr_error);
    end
    load_word(32'h40, 32'hBAD0_BAD0);
    n_checks++;
    if (addr_error !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL oor_write_flag: got addr_error=%b, expected 1", addr_error);
    end
    enter_run();
    sb.push_back('{32'h11, 32'd4, 1'b1});
    tick();
    e = sb.pop_front();
    n_checks++;
    if ({if_id_instruction, if_id_pc_plus4, if_id_valid} !== e) begin
      n_fail++;
      $display("[TB] FAIL oor_write_alias: got instr=%h pc4=%h valid=%b, expected instr=%h pc4=%h valid=%b",
               if_id_instruction, if_id_pc_plus4, if_id_valid, e.instr, e.pc4, e.valid);
    end
    abort_run();
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (addr_error !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL oor_reset_clear: got addr_error=%b, expected 0", addr_error);
    end
    reset = 1'b1;
    enter_run();
    tick();
    jump = 1'b1; pc_with_jump = 32'h40;
    tick();
    jump = 1'b0;
    n_checks++;
    if ({program_counter, addr_error} !== {32'h40, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL oor_jump: got pc=%h addr_error=%b, expected 00000040 0", program_counter, addr_error);
    end
    sb.push_back('{32'h0, 32'h44, 1'b1});
    tick();
    e = sb.pop_front();
    n_checks++;
    if ({if_id_instruction, if_id_pc_plus4, if_id_valid, addr_error} !== {e, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL oor_fetch: got instr=%h pc4=%h valid=%b addr_error=%b, expected instr=%h pc4=%h valid=%b addr_error=1",
               if_id_instruction, if_id_pc_plus4, if_id_valid, addr_error, e.instr, e.pc4, e.valid);
    end
    abort_run();
    n_checks++;
    if (addr_error !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL oor_sticky: got addr_error=%b, expected 1", addr_error);
    end
  endtask

  task automatic test_write_gating();
    exp_t e;
    enter_run();
    wr_en = 1'b1; address_to_write = 32'h0; instruction_to_write = 32'hDEAD;
    tick();
    wr_en = 1'b0;
    abort_run();
    n_checks++;
    if ({program_counter, if_id_valid} !== {32'h0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL abort_load: got pc=%h valid=%b, expected 00000000 0", program_counter, if_id_valid);
    end
    enter_run();
    sb.push_back('{32'h11, 32'd4, 1'b1});
    tick();
    e = sb.pop_front();
    n_checks++;
    if ({if_id_instruction, if_id_pc_plus4, if_id_valid} !== e) begin
      n_fail++;
      $display("[TB] FAIL write_gating: got instr=%h pc4=%h valid=%b, expected instr=%h pc4=%h valid=%b",
               if_id_instruction, if_id_pc_plus4, if_id_valid, e.instr, e.pc4, e.valid);
    end
    abort_run();
  endtask

  // Bound the whole run so a stuck design still ends the simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_load_run();
    test_stall();
    test_jump_stall();
    test_async_reset();
    test_out_of_range();
    test_write_gating();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
